// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: stall bit indices, stall patterns,
// controller FSM encoding and address-bus constants.
package pipe_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam logic [InstAddrBus-1:0] ZeroWord = '0;

    localparam int STALL_W     = 5;
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;

    // A stage holds itself and every register upstream of it.
    localparam logic [STALL_W-1:0] PAT_NONE = 5'b00000;
    localparam logic [STALL_W-1:0] PAT_IF   = 5'b00011;
    localparam logic [STALL_W-1:0] PAT_ID   = 5'b00011;
    localparam logic [STALL_W-1:0] PAT_EX   = 5'b00111;
    localparam logic [STALL_W-1:0] PAT_MEM  = 5'b01111;
    localparam logic [STALL_W-1:0] PAT_ALL  = 5'b11111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running 32-bit performance counters (cycles, stalled cycles, flushes),
// each wrapping modulo 2^32 and cleared by rst.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_any,
    input  logic        flush,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes
);

    logic [2:0]  inc;
    logic [31:0] cnt_reg [3];

    assign inc = {flush, stall_any, 1'b1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_cycles  = cnt_reg[0];
    assign perf_stalls  = cnt_reg[1];
    assign perf_flushes = cnt_reg[2];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception redirect and stall watchdog.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   excp_req,
    input  logic [InstAddrBus-1:0] excp_pc,
    output logic [STALL_W-1:0]     stall,
    output logic                   flush,
    output logic [InstAddrBus-1:0] new_pc,
    output logic                   excp_ack,
    output logic                   wdog_err,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stalls,
    output logic [31:0]            perf_flushes
);

    localparam logic [15:0] WDOG_MAX = 16'(WDOG_LIMIT);

    state_t                 state_reg;
    logic                   flush_reg;
    logic                   excp_ack_reg;
    logic [InstAddrBus-1:0] new_pc_reg;
    logic [15:0]            wdog_cnt_reg;
    logic [15:0]            wdog_cnt_next;
    logic                   wdog_err_reg;

    // Only RUN honours requests; an accepted exception freezes everything.
    always_comb begin
        stall = PAT_NONE;
        if (!rst && state_reg == ST_RUN) begin
            if (excp_req)          stall = PAT_ALL;
            else if (stallreq_mem) stall = PAT_MEM;
            else if (stallreq_ex)  stall = PAT_EX;
            else if (stallreq_id)  stall = PAT_ID;
            else if (stallreq_if)  stall = PAT_IF;
        end
    end

    always_comb begin
        wdog_cnt_next = '0;
        if (state_reg == ST_RUN && stall != PAT_NONE) begin
            wdog_cnt_next = (wdog_cnt_reg == WDOG_MAX) ? WDOG_MAX : wdog_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            flush_reg    <= 1'b0;
            excp_ack_reg <= 1'b0;
            new_pc_reg   <= ZeroWord;
            wdog_cnt_reg <= '0;
            wdog_err_reg <= 1'b0;
        end else begin
            wdog_cnt_reg <= wdog_cnt_next;
            if (wdog_cnt_next == WDOG_MAX) begin
                wdog_err_reg <= 1'b1;
            end
            flush_reg    <= 1'b0;
            excp_ack_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (excp_req) begin
                        state_reg    <= ST_FLUSH;
                        flush_reg    <= 1'b1;
                        excp_ack_reg <= 1'b1;
                        new_pc_reg   <= excp_pc;
                    end
                end
                ST_FLUSH:   state_reg <= ST_RECOVER;
                ST_RECOVER: state_reg <= ST_RUN;
                default:    state_reg <= ST_RUN;
            endcase
        end
    end

    assign flush    = flush_reg;
    assign excp_ack = excp_ack_reg;
    assign new_pc   = new_pc_reg;
    assign wdog_err = wdog_err_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_any;

    assign stall_any = (stall != PAT_NONE);

    pipe_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_any    (stall_any),
        .flush        (flush_reg),
        .perf_cycles  (perf_cycles),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
    );
`else
    assign perf_cycles  = '0;
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic [4:0]  stall;
    logic        flush, excp_ack, wdog_err;
    logic [31:0] new_pc, perf_cycles, perf_stalls, perf_flushes;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_req     (excp_req),
        .excp_pc      (excp_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .excp_ack     (excp_ack),
        .wdog_err     (wdog_err),
        .perf_cycles  (perf_cycles),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
    );

    typedef struct {
        logic [3:0]  req;   // {mem, ex, id, if}
        logic        e;
        logic [31:0] pc;
        logic [4:0]  s;
        logic        f;
        logic [31:0] npc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic set_in(input logic r, input logic [3:0] req, input logic e, input logic [31:0] pc);
        rst = r;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excp_req = e;
        excp_pc  = pc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 4'b0000, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic e, input logic [31:0] pc,
                                input logic [4:0] s, input logic f, input logic [31:0] npc);
        vec_t v;
        v.req = req; v.e = e; v.pc = pc; v.s = s; v.f = f; v.npc = npc;
        return v;
    endfunction

    // Highest requesting stage k holds registers 0..k: mask = 2^(k+1)-1.
    function automatic logic [4:0] prio_stall(input logic [3:0] req);
        int top;
        top = req[3] ? 4 : req[2] ? 3 : (req[1] | req[0]) ? 2 : 0;
        return 5'((1 << top) - 1);
    endfunction

    initial begin
        int m_phase, m_run;
        logic m_flush, m_err;
        logic [31:0] m_pc, m_cyc, m_stl, m_fls;
        logic [4:0]  exp_stall;
        logic [3:0]  rq;
        logic        r, e;
        logic [31:0] pc;

        set_in(1'b1, 4'b0000, 1'b0, 32'h0);

        // Reset state, with requests active: stall must stay quiet.
        set_in(1'b1, 4'b1111, 1'b1, 32'hFFFF_FFFF);
        next_cycle();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_ack", 32'(excp_ack), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_wdog", 32'(wdog_err), 32'h0);
        chk("rst_perf_cycles", perf_cycles, 32'h0);
        $display("reset: stall=%b flush=%b new_pc=%h", stall, flush, new_pc);

        // Directed vectors; row index == cycle number after reset.
        vq.push_back(mk(4'b0000, 0, 32'h0,         5'b00000, 0, 32'h0));
        vq.push_back(mk(4'b1010, 0, 32'h0,         5'b01111, 0, 32'h0));
        vq.push_back(mk(4'b0000, 0, 32'h0,         5'b00000, 0, 32'h0));
        vq.push_back(mk(4'b0001, 0, 32'h0,         5'b00011, 0, 32'h0));
        vq.push_back(mk(4'b0000, 0, 32'h0,         5'b00000, 0, 32'h0));
        vq.push_back(mk(4'b0100, 0, 32'h0,         5'b00111, 0, 32'h0));
        vq.push_back(mk(4'b1000, 0, 32'h0,         5'b01111, 0, 32'h0));
        vq.push_back(mk(4'b0101, 0, 32'h0,         5'b00111, 0, 32'h0));
        vq.push_back(mk(4'b0000, 0, 32'h0,         5'b00000, 0, 32'h0));
        vq.push_back(mk(4'b0010, 0, 32'h0,         5'b00011, 0, 32'h0));
        vq.push_back(mk(4'b0000, 1, 32'hBFC00380, 5'b11111, 0, 32'h0));
        vq.push_back(mk(4'b0000, 1, 32'hDEADBEEF, 5'b00000, 1, 32'hBFC00380));
        vq.push_back(mk(4'b0100, 0, 32'h0,         5'b00000, 0, 32'hBFC00380));
        vq.push_back(mk(4'b0100, 0, 32'h0,         5'b00111, 0, 32'hBFC00380));
        vq.push_back(mk(4'b0100, 1, 32'h80000180, 5'b11111, 0, 32'hBFC00380));
        vq.push_back(mk(4'b0100, 1, 32'h12345678, 5'b00000, 1, 32'h80000180));
        vq.push_back(mk(4'b0100, 0, 32'h0,         5'b00000, 0, 32'h80000180));
        vq.push_back(mk(4'b0000, 0, 32'h0,         5'b00000, 0, 32'h80000180));
        vq.push_back(mk(4'b0000, 1, 32'h11111111, 5'b11111, 0, 32'h80000180));
        vq.push_back(mk(4'b0000, 1, 32'h11111111, 5'b00000, 1, 32'h11111111));
        vq.push_back(mk(4'b0000, 1, 32'h11111111, 5'b00000, 0, 32'h11111111));
        vq.push_back(mk(4'b0000, 1, 32'h22222222, 5'b11111, 0, 32'h11111111));
        vq.push_back(mk(4'b0000, 1, 32'h33333333, 5'b00000, 1, 32'h22222222));
        vq.push_back(mk(4'b0000, 0, 32'h0,         5'b00000, 0, 32'h22222222));
        vq.push_back(mk(4'b1000, 0, 32'h0,         5'b01111, 0, 32'h22222222));

        do_reset();
        foreach (vq[i]) begin
            set_in(1'b0, vq[i].req, vq[i].e, vq[i].pc);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vq[i].s));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vq[i].f));
            chk($sformatf("vec%0d_ack", i), 32'(excp_ack), 32'(vq[i].f));
            chk($sformatf("vec%0d_new_pc", i), new_pc, vq[i].npc);
            chk($sformatf("vec%0d_wdog", i), 32'(wdog_err), 32'h0);
            $display("vec %0d: req=%b excp=%b stall=%b flush=%b new_pc=%h",
                     i, vq[i].req, vq[i].e, stall, flush, new_pc);
            next_cycle();
        end

        // Watchdog: six stalled cycles with limit 4, sticky after release.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            set_in(1'b0, 4'b0100, 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("wdog_stalled%0d", k), 32'(wdog_err), 32'(k >= 5));
            chk($sformatf("wdog_stall%0d", k), 32'(stall), 32'b00111);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 4'b0000, 1'b0, 32'h0);
            @(negedge clk);
            chk("wdog_sticky", 32'(wdog_err), 32'h1);
            next_cycle();
        end
        set_in(1'b1, 4'b0000, 1'b0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("wdog_cleared", 32'(wdog_err), 32'h0);
        $display("watchdog sequence done: wdog_err=%b", wdog_err);

        // Reset during FLUSH aborts the exception.
        do_reset();
        set_in(1'b0, 4'b0000, 1'b1, 32'hBFC00380);
        @(negedge clk);
        chk("abort_accept_stall", 32'(stall), 32'b11111);
        next_cycle();
        set_in(1'b1, 4'b0100, 1'b1, 32'hBFC00380);
        @(negedge clk);
        chk("abort_in_flush", 32'(flush), 32'h1);
        chk("abort_rst_stall", 32'(stall), 32'h0);
        next_cycle();
        set_in(1'b0, 4'b0100, 1'b0, 32'h0);
        @(negedge clk);
        chk("abort_flush", 32'(flush), 32'h0);
        chk("abort_ack", 32'(excp_ack), 32'h0);
        chk("abort_new_pc", new_pc, 32'h0);
        chk("abort_perf_flushes", perf_flushes, 32'h0);
        chk("abort_run_stall", 32'(stall), 32'b00111);
        next_cycle();
        set_in(1'b0, 4'b0000, 1'b0, 32'h0);
        @(negedge clk);
        chk("abort_no_pending", 32'(flush), 32'h0);
        $display("reset-in-flush sequence done: flush=%b new_pc=%h", flush, new_pc);
        next_cycle();

        // 20 cycles: 3 stalled cycles plus one exception.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            set_in(1'b0, (c >= 2 && c <= 4) ? 4'b0010 : 4'b0000, (c == 10 || c == 11), 32'hBFC00380);
            next_cycle();
        end
        set_in(1'b0, 4'b0000, 1'b0, 32'h0);
        @(negedge clk);
        chk("perf_cycles", perf_cycles, perf_exp(32'd20));
        chk("perf_stalls", perf_stalls, perf_exp(32'd4));
        chk("perf_flushes", perf_flushes, perf_exp(32'd1));
        $display("perf sequence: cycles=%0d stalls=%0d flushes=%0d", perf_cycles, perf_stalls, perf_flushes);
        next_cycle();

        // Randomized traffic against the behavioural model.
        do_reset();
        m_phase = 0; m_run = 0; m_flush = 0; m_err = 0;
        m_pc = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            rq = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            e  = ($urandom_range(0, 5) == 0);
            pc = $urandom;
            set_in(r, rq, e, pc);
            if (r || m_phase != 0) exp_stall = 5'b00000;
            else if (e)            exp_stall = 5'b11111;
            else                   exp_stall = prio_stall(rq);
            @(negedge clk);
            chk("rnd_stall", 32'(stall), 32'(exp_stall));
            chk("rnd_flush", 32'(flush), 32'(m_flush));
            chk("rnd_ack", 32'(excp_ack), 32'(m_flush));
            chk("rnd_new_pc", new_pc, m_pc);
            chk("rnd_wdog", 32'(wdog_err), 32'(m_err));
            chk("rnd_perf_cycles", perf_cycles, perf_exp(m_cyc));
            chk("rnd_perf_stalls", perf_stalls, perf_exp(m_stl));
            chk("rnd_perf_flushes", perf_flushes, perf_exp(m_fls));
            if (r) begin
                m_phase = 0; m_run = 0; m_flush = 0; m_err = 0;
                m_pc = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
            end else begin
                m_cyc++;
                if (exp_stall != 0) m_stl++;
                if (m_flush) m_fls++;
                if (m_phase == 0 && exp_stall != 0) m_run++;
                else m_run = 0;
                if (m_run >= LIMIT) m_err = 1'b1;
                if (m_phase == 0 && e) begin
                    m_phase = 2;
                    m_pc    = pc;
                end else if (m_phase > 0) begin
                    m_phase--;
                end
                m_flush = (m_phase == 2);
            end
            next_cycle();
        end
        $display("random phase done: 600 cycles");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
